// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

    localparam int DEFAULT_DEPTH       = 1024;
    localparam int DEFAULT_WAIT_STATES = 1;
    localparam int ADDR_W              = 10;
    localparam int DATA_W              = 32;
    localparam int BE_W                = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    // Replace only the bytes of old_word whose enable bit is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_word;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 storage: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx;

    // Callers gate we_i with the range check, so the low address bits suffice.
    assign idx     = addr_i[IDX_W-1:0];
    assign rdata_o = mem_q[idx];

    // Byte-masked write of the addressed word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx] <= merge_bytes(mem_q[idx], wdata_i, be_i);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: accept, optional wait states,
// one access cycle, then hold the response until the core takes it.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign in_range  = {{(32-ADDR_W){1'b0}}, addr_q} < DEPTH_W;
    assign mem_we    = (state_q == ACCESS) && wr_q && in_range;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    mem_array #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (mem_we),
        .addr_i (addr_q),
        .wdata_i(wdata_q),
        .be_i   (be_q),
        .rdata_o(mem_rdata)
    );

    // State, wait counter, latched request and response registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state, handshake outputs and response capture.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = !Reset;
                if (req_valid) begin
                    wr_d       = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    be_d       = req_be;
                    wait_cnt_d = WS_INIT;
                    state_d    = (WS_INIT != 4'd0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = (in_range && !wr_q) ? mem_rdata : '0;
                err_d   = !in_range;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder over four parameterisations:
// 0: DEPTH 1024 / WS 1, 1: DEPTH 512 / WS 1, 2: DEPTH 1024 / WS 3, 3: DEPTH 1024 / WS 0.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        Reset     [4];
    logic        req_valid [4];
    logic        req_ready [4];
    logic        req_write [4];
    logic [9:0]  req_addr  [4];
    logic [31:0] req_wdata [4];
    logic [3:0]  req_be    [4];
    logic        rsp_valid [4];
    logic        rsp_ready [4];
    logic [31:0] rsp_rdata [4];
    logic        rsp_err   [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int P_DEPTH = (g == 1) ? 512 : 1024;
        localparam int P_WS    = (g == 2) ? 3 : ((g == 3) ? 0 : 1);
        data_mem_responder #(
            .DEPTH(P_DEPTH),
            .WAIT_STATES(P_WS)
        ) u_dut (
            .clk      (clk),
            .Reset    (Reset[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int unsigned acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   busy[4];

    function automatic int ws_of(input int i);
        return (i == 2) ? 3 : ((i == 3) ? 0 : 1);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    // Monitor: on the first cycle a response is presented, compare it with the queue head.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid[i] && !busy[i]) begin
                busy[i] = 1'b1;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp dut%0d got=valid exp=none", i);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_dut", i, 32'(i), 32'(e.idx));
                    chk("rsp_rdata", i, rsp_rdata[i], e.rdata);
                    chk("rsp_err", i, {31'b0, rsp_err[i]}, {31'b0, e.err});
                    chk("latency", i, 32'(cyc + 1 - e.acc), 32'(ws_of(i) + 2));
                end
            end else if (!rsp_valid[i]) begin
                busy[i] = 1'b0;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int idx, input logic wr, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] er, input logic ee, input bit push);
        int n = 0;
        while (!req_ready[idx] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready[idx]) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout dut%0d got=0 exp=1", idx);
        end
        req_valid[idx] = 1'b1;
        req_write[idx] = wr;
        req_addr[idx]  = a;
        req_wdata[idx] = d;
        req_be[idx]    = be;
        if (push) sbq.push_back('{idx: idx, rdata: er, err: ee, acc: cyc + 1});
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_resp(input int idx);
        int n = 0;
        while (!(rsp_valid[idx] && rsp_ready[idx]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(rsp_valid[idx] && rsp_ready[idx])) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout dut%0d got=0 exp=1", idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int idx, input logic wr, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] er, input logic ee);
        issue(idx, wr, a, d, be, er, ee, 1'b1);
        wait_resp(idx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            Reset[i]     = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
            rsp_ready[i] = 1'b1;
        end

        // Reset state: not ready while Reset is high, ready on the first cycle after.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("ready_in_reset", i, {31'b0, req_ready[i]}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) Reset[i] = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("ready_after_reset", i, {31'b0, req_ready[i]}, 32'd1);
            chk("valid_after_reset", i, {31'b0, rsp_valid[i]}, 32'd0);
            chk("rdata_after_reset", i, rsp_rdata[i], 32'd0);
            chk("err_after_reset", i, {31'b0, rsp_err[i]}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Store then load.
        do_req(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        do_req(0, 1'b0, 10'd5, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        // Byte enables.
        do_req(0, 1'b1, 10'd7, 32'h11223344, 4'b1111, 32'h0, 1'b0);
        do_req(0, 1'b1, 10'd7, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        do_req(0, 1'b0, 10'd7, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);

        // Backpressure: response held, new requests ignored.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 10'd5, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            req_valid[0] = 1'b1;
            req_write[0] = 1'b1;
            req_addr[0]  = 10'd5;
            req_wdata[0] = 32'h0;
            req_be[0]    = 4'b1111;
            @(negedge clk);
            chk("bp_valid", 0, {31'b0, rsp_valid[0]}, 32'd1);
            chk("bp_rdata", 0, rsp_rdata[0], 32'hDEADBEEF);
            chk("bp_ready", 0, {31'b0, req_ready[0]}, 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_drop", 0, {31'b0, rsp_valid[0]}, 32'd0);
        chk("bp_ready_rise", 0, {31'b0, req_ready[0]}, 32'd1);
        do_req(0, 1'b0, 10'd5, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        // Out of range with DEPTH 512; 600 aliases to 88 in the low bits.
        do_req(1, 1'b1, 10'd88, 32'h12345678, 4'b1111, 32'h0, 1'b0);
        do_req(1, 1'b1, 10'd600, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b1);
        do_req(1, 1'b0, 10'd88, 32'h0, 4'b0000, 32'h12345678, 1'b0);
        do_req(1, 1'b0, 10'd600, 32'h0, 4'b0000, 32'h0, 1'b1);

        // Reset in the second wait cycle abandons the store.
        do_req(2, 1'b1, 10'd9, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0);
        do_req(2, 1'b0, 10'd9, 32'h0, 4'b0000, 32'hA5A5A5A5, 1'b0);
        issue(2, 1'b1, 10'd9, 32'h00000001, 4'b1111, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        Reset[2] = 1'b1;
        #1;
        chk("ready_during_reset", 2, {31'b0, req_ready[2]}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_reset_valid", 2, {31'b0, rsp_valid[2]}, 32'd0);
        chk("mid_reset_rdata", 2, rsp_rdata[2], 32'd0);
        chk("mid_reset_err", 2, {31'b0, rsp_err[2]}, 32'd0);
        Reset[2] = 1'b0;
        #1;
        chk("mid_reset_ready", 2, {31'b0, req_ready[2]}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        do_req(2, 1'b0, 10'd9, 32'h0, 4'b0000, 32'hA5A5A5A5, 1'b0);

        // No wait states, empty byte-enable store leaves memory unchanged.
        do_req(3, 1'b1, 10'd3, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0);
        do_req(3, 1'b1, 10'd3, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        do_req(3, 1'b0, 10'd3, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 0, 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
